phy_tx_crc_framer: RTL and testbench

PHY_TX_CRC_FRAMER -- requirements
Module: phy_tx_crc_framer

---
 rtl/phy_tx_crc_framer.sv | 148 ++++++++++++++
 tb/tb_phy_tx_crc_framer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_crc_framer.sv
// Byte-to-nibble transmit framer that appends a reflected CRC-32 tail, LS nibble first.
// Each byte goes out as two nibbles. The CRC accumulates across starvation gaps and restarts only after a completed or aborted frame.
module phy_tx_crc_framer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        nib_valid,
   output logic [3:0]  nib_data,
   output logic        nib_last,
   input  logic        nib_ready,
   output logic [31:0] crc_value,
   output logic        tx_done
);
   localparam int unsigned CRC_W   = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned CNT_W   = 3;
   localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB88320;
   localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {IDLE, LO, HI, CRC} state_e;

   state_e             state_q, state_d;
   logic [BYTE_W-1:0]  buf_q, buf_d;
   logic               last_q, last_d;
   logic [CRC_W-1:0]   crc_q, crc_d;
   logic [CRC_W-1:0]   crc_value_q, crc_value_d;
   logic [CNT_W-1:0]   crc_cnt_q, crc_cnt_d;
   logic               tx_done_q, tx_done_d;
   logic [CRC_W-1:0]   crc_tx;
   logic               nib_hs;
   logic               in_hs;

   // One nibble through the reflected CRC-32 register, LSB first.
   function automatic logic [CRC_W-1:0] crc_nibble(input logic [CRC_W-1:0] c,
                                                   input logic [3:0]       n);
      logic [CRC_W-1:0] r;
      r = c ^ {28'h0, n};
      for (int i = 0; i < 4; i++) begin
         r = (r >> 1) ^ (r[0] ? CRC_POLY : '0);
      end
      return r;
   endfunction

   assign crc_tx = ~crc_q;

   always_comb begin
      nib_valid = (state_q != IDLE);
      nib_last  = (state_q == CRC) && (crc_cnt_q == CNT_W'(7));
      nib_data  = '0;
      case (state_q)
         LO:      nib_data = buf_q[3:0];
         HI:      nib_data = buf_q[7:4];
         CRC:     nib_data = crc_tx[{crc_cnt_q, 2'b00} +: 4];
         default: nib_data = '0;
      endcase
   end

   // HI only hands over to the next byte when its own nibble leaves in the same cycle.
   assign in_ready = !abort && ((state_q == IDLE) ||
                                (state_q == HI && nib_ready && !last_q));
   assign nib_hs   = nib_valid && nib_ready;
   assign in_hs    = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      last_d      = last_q;
      crc_d       = crc_q;
      crc_value_d = crc_value_q;
      crc_cnt_d   = crc_cnt_q;
      tx_done_d   = 1'b0;
      if (abort) begin
         state_d   = IDLE;
         crc_cnt_d = '0;
         crc_d     = CRC_INIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_hs) begin
                  buf_d   = in_data;
                  last_d  = in_last;
                  state_d = LO;
               end
            end
            LO: begin
               if (nib_hs) begin
                  crc_d   = crc_nibble(crc_q, buf_q[3:0]);
                  state_d = HI;
               end
            end
            HI: begin
               if (nib_hs) begin
                  crc_d = crc_nibble(crc_q, buf_q[7:4]);
                  if (last_q) begin
                     state_d   = CRC;
                     crc_cnt_d = '0;
                  end else if (in_hs) begin
                     buf_d   = in_data;
                     last_d  = in_last;
                     state_d = LO;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            CRC: begin
               if (nib_hs) begin
                  crc_cnt_d = crc_cnt_q + CNT_W'(1);
                  if (crc_cnt_q == CNT_W'(7)) begin
                     crc_value_d = crc_tx;
                     tx_done_d   = 1'b1;
                     crc_d       = CRC_INIT;
                     state_d     = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         last_q      <= 1'b0;
         crc_q       <= CRC_INIT;
         crc_value_q <= '0;
         crc_cnt_q   <= '0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         last_q      <= last_d;
         crc_q       <= crc_d;
         crc_value_q <= crc_value_d;
         crc_cnt_q   <= crc_cnt_d;
         tx_done_q   <= tx_done_d;
      end
   end

   assign crc_value = crc_value_q;
   assign tx_done   = tx_done_q;
endmodule

// File: tb/tb_phy_tx_crc_framer.sv
// Scoreboard bench for phy_tx_crc_framer against a bytewise reflected CRC-32 reference.
module tb_phy_tx_crc_framer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        nib_valid;
   logic [3:0]  nib_data;
   logic        nib_last;
   logic        nib_ready = 1'b1;
   logic [31:0] crc_value;
   logic        tx_done;

   int checks = 0;
   int failures = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the main sequence

   typedef struct packed {
      logic [3:0] d;
      logic       l;
   } nib_t;
   typedef logic [7:0] bq_t[$];

   nib_t        exp_nib[$];
   logic [31:0] exp_crc[$];

   phy_tx_crc_framer dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .nib_valid(nib_valid), .nib_data(nib_data), .nib_last(nib_last), .nib_ready(nib_ready),
      .crc_value(crc_value), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Transmitted CRC-32 (reflected, init and final XOR all ones), processed a whole byte at a time.
   function automatic logic [31:0] ref_crc(input bq_t bytes);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (bytes[i]) begin
         c = c ^ {24'h0, bytes[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic push_frame_exp(input bq_t bytes);
      logic [31:0] c;
      nib_t n;
      foreach (bytes[i]) begin
         n.d = bytes[i][3:0]; n.l = 1'b0; exp_nib.push_back(n);
         n.d = bytes[i][7:4]; n.l = 1'b0; exp_nib.push_back(n);
      end
      c = ref_crc(bytes);
      for (int k = 0; k < 8; k++) begin
         n.d = c[4*k +: 4];
         n.l = (k == 7);
         exp_nib.push_back(n);
      end
      exp_crc.push_back(c);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_data = b; in_last = last;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL in_handshake_timeout actual=no_ready required=ready");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk("latency_valid", 32'(nib_valid), 32'd1);
      chk("latency_lo_nib", 32'(nib_data), 32'(b[3:0]));
   endtask

   task automatic send_frame(input bq_t bytes, input bit gaps);
      int n;
      push_frame_exp(bytes);
      foreach (bytes[i]) begin
         send_byte(bytes[i], i == bytes.size() - 1);
         if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (exp_nib.size() == 0 && exp_crc.size() == 0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_timeout actual=nib_left_%0d_crc_left_%0d required=0", exp_nib.size(), exp_crc.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
      chk({tag, "_nib_valid"}, 32'(nib_valid), 32'd0);
      chk({tag, "_nib_data"},  32'(nib_data),  32'd0);
      chk({tag, "_nib_last"},  32'(nib_last),  32'd0);
      chk({tag, "_crc_value"}, crc_value,      32'd0);
      chk({tag, "_tx_done"},   32'(tx_done),   32'd0);
   endtask

   function automatic bq_t digits();
      bq_t q;
      for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
      return q;
   endfunction

   // Downstream ready generator.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 0)      nib_ready = 1'b1;
         else if (ready_mode == 1) nib_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: pops the scoreboard on every nibble handshake and every tx_done pulse.
   initial begin
      bit         prev_stall;
      bit         prev_abort;
      logic [3:0] prev_d;
      logic       prev_l;
      nib_t       e;
      prev_stall = 1'b0; prev_abort = 1'b0; prev_d = '0; prev_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !prev_abort) begin
               chk("stall_valid", 32'(nib_valid), 32'd1);
               chk("stall_data",  32'(nib_data),  32'(prev_d));
               chk("stall_last",  32'(nib_last),  32'(prev_l));
            end
            if (nib_valid && nib_ready && !abort) begin
               if (exp_nib.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_nibble actual=%h required=none", nib_data);
               end else begin
                  e = exp_nib.pop_front();
                  chk("nib_data", 32'(nib_data), 32'(e.d));
                  chk("nib_last", 32'(nib_last), 32'(e.l));
               end
            end
            if (tx_done) begin
               if (exp_crc.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_tx_done actual=1 required=0");
               end else begin
                  chk("crc_value_model", crc_value, exp_crc.pop_front());
               end
            end
            prev_stall = nib_valid && !nib_ready;
            prev_abort = abort;
            prev_d     = nib_data;
            prev_l     = nib_last;
         end
      end
   end

   initial begin
      bq_t  q;
      bq_t  a5;
      nib_t n;
      logic [31:0] c;
      int len;

      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("post_rst");

      // Check value from a clean channel
      send_frame(digits(), 1'b0);
      wait_drain();
      chk("digits_crc", crc_value, 32'hCBF43926);

      q = {8'h00};
      send_frame(q, 1'b0);
      wait_drain();
      chk("zero_byte_crc", crc_value, 32'hD202EF8D);

      // Stalls and upstream starvation must not alter the stream
      ready_mode = 1;
      send_frame(digits(), 1'b1);
      wait_drain();
      chk("stalled_digits_crc", crc_value, 32'hCBF43926);

      ready_mode = 0;
      send_frame(digits(), 1'b0);
      send_frame(digits(), 1'b0);
      wait_drain();
      chk("b2b_digits_crc", crc_value, 32'hCBF43926);

      // Abort while idle blocks input
      abort = 1'b1;
      @(negedge clk);
      chk("abort_idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;

      // Abort in the CRC tail at crc_cnt==3
      ready_mode = 2;
      nib_ready  = 1'b1;
      a5 = {8'hA5};
      c  = ref_crc(a5);
      n.l = 1'b0;
      n.d = 4'h5;     exp_nib.push_back(n);
      n.d = 4'hA;     exp_nib.push_back(n);
      n.d = c[3:0];   exp_nib.push_back(n);
      n.d = c[7:4];   exp_nib.push_back(n);
      n.d = c[11:8];  exp_nib.push_back(n);
      send_byte(8'hA5, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_at_cnt3_data", 32'(nib_data), 32'(c[15:12]));
      nib_ready = 1'b0;
      abort     = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      nib_ready = 1'b1;
      chk("abort_nib_valid", 32'(nib_valid), 32'd0);
      ready_mode = 0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_crc_hold", crc_value, 32'hCBF43926);
      chk("abort_exp_empty", 32'(exp_nib.size()), 32'd0);
      q = {8'h00};
      send_frame(q, 1'b0);
      wait_drain();
      chk("post_abort_crc", crc_value, 32'hD202EF8D);

      // Reset while the first byte's high nibble is on the wire
      n.d = 4'h1; n.l = 1'b0; exp_nib.push_back(n);
      send_byte(8'h31, 1'b0);
      @(posedge clk); #1;
      chk("midrst_hi_nib", 32'(nib_data), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("midrst_rel");
      send_frame(digits(), 1'b0);
      wait_drain();
      chk("post_reset_crc", crc_value, 32'hCBF43926);

      // Random frames with random stalls and gaps
      ready_mode = 1;
      for (int f = 0; f < 15; f++) begin
         q = {};
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         send_frame(q, ($urandom_range(0, 1) == 1));
      end
      wait_drain();
      ready_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
